// File: rtl/freq_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : freq_meter
//  Purpose  : Gated frequency counter. Counts rising edges of an asynchronous
//             square wave over a fixed window of GATE_CYCLES system clocks and
//             publishes the count with a one-cycle valid strobe. An LED output
//             toggles once per completed window as a heartbeat.
//  Ports    : clk        - system clock
//             rst        - synchronous, active-high reset
//             sig_in     - asynchronous signal under measurement
//             meas_en    - 1 = run windows back to back, 0 = idle / abort
//             freq       - edge count of the last completed window
//             freq_ovf   - last completed window saturated
//             freq_valid - one-cycle strobe when freq / freq_ovf update
//             led        - toggles on every completed window
//  Revision : 1.0 - initial release
// ============================================================================
module freq_meter #(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             meas_en,
    output logic [CNT_W-1:0] freq,
    output logic             freq_ovf,
    output logic             freq_valid,
    output logic             led
);

    localparam int                  c_gate_w  = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [c_gate_w-1:0] c_last    = c_gate_w'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    c_cnt_max = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_GATE = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_sync1;
    logic                r_sync2;
    logic                r_dly;
    logic [c_gate_w-1:0] r_gate_cnt;
    logic [CNT_W-1:0]    r_edge_cnt;
    logic                r_ovf;

    logic                w_edge;
    logic                w_at_max;
    logic                w_edge_sat;
    logic [CNT_W-1:0]    w_edge_inc;
    logic                w_final;
    logic                w_counting;

    // Two-flop synchroniser plus one delay stage for edge detection. Runs in
    // every state so the first GATE cycle already sees a settled history.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_dly   <= 1'b0;
        end else begin
            r_sync1 <= sig_in;
            r_sync2 <= r_sync1;
            r_dly   <= r_sync2;
        end
    end

    assign w_edge     = r_sync2 & ~r_dly;
    assign w_at_max   = (r_edge_cnt == c_cnt_max);
    // An edge arriving while already saturated marks the window as overflowed.
    assign w_edge_sat = w_edge & w_at_max;
    // Count including this cycle's edge, saturated; used both for the running
    // count and for the published result so an edge on the final cycle still
    // belongs to the ending window.
    assign w_edge_inc = (w_edge && !w_at_max) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_final      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (meas_en) begin
                    w_state_next = ST_GATE;
                end
            end
            ST_GATE: begin
                // Final-cycle handling takes precedence over an abort so a
                // window that completes is always published.
                if (r_gate_cnt == c_last) begin
                    w_final = 1'b1;
                end
                if (!meas_en) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Counters advance only inside a window that continues past this cycle;
    // completion, abort and IDLE all clear them.
    assign w_counting = (r_state == ST_GATE) && meas_en && !w_final;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf      <= 1'b0;
            freq       <= '0;
            freq_ovf   <= 1'b0;
            freq_valid <= 1'b0;
            led        <= 1'b0;
        end else begin
            freq_valid <= w_final;
            if (w_counting) begin
                r_gate_cnt <= r_gate_cnt + c_gate_w'(1);
                r_edge_cnt <= w_edge_inc;
                r_ovf      <= r_ovf | w_edge_sat;
            end else begin
                r_gate_cnt <= '0;
                r_edge_cnt <= '0;
                r_ovf      <= 1'b0;
            end
            if (w_final) begin
                freq     <= w_edge_inc;
                freq_ovf <= r_ovf | w_edge_sat;
                led      <= ~led;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_freq_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_freq_meter
//  Purpose  : Self-checking bench for freq_meter. A reference model counts
//             rising transitions of the clock-sampled input history over each
//             window and predicts the strobe, result and LED every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_freq_meter;

    localparam int c_g    = 100;
    localparam int c_w    = 5;
    localparam int c_maxc = (1 << c_w) - 1;
    localparam int c_hist = 16384;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           sig_in;
    logic           meas_en = 1'b0;
    logic [c_w-1:0] freq;
    logic           freq_ovf;
    logic           freq_valid;
    logic           led;

    freq_meter #(
        .GATE_CYCLES(c_g),
        .CNT_W      (c_w)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sig_in    (sig_in),
        .meas_en   (meas_en),
        .freq      (freq),
        .freq_ovf  (freq_ovf),
        .freq_valid(freq_valid),
        .led       (led)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Input history as seen at each rising clock edge.
    bit   s_hist [c_hist];
    bit   r_hist [c_hist];
    logic p_rst;
    logic p_en;

    always @(posedge clk) begin
        if (cyc < c_hist) begin
            s_hist[cyc] <= sig_in;
            r_hist[cyc] <= rst;
        end
        p_rst <= rst;
        p_en  <= meas_en;
        cyc   <= cyc + 1;
    end

    // Sample as seen by the meter: reset clears its input history.
    function automatic bit eff(input int k);
        return (k >= 0) && s_hist[k] && !r_hist[k];
    endfunction

    // Rising transitions whose detection falls in clock cycles ws..we.
    // Detection in cycle m compares the samples from edges m-1 and m-2.
    function automatic int window_rises(input int ws, input int we);
        int c = 0;
        for (int m = ws; m <= we; m++) begin
            if (eff(m - 1) && !eff(m - 2)) c++;
        end
        return c;
    endfunction

    bit m_active = 1'b0;
    int m_ws     = 0;
    int e_freq   = 0;
    bit e_ovf    = 1'b0;
    bit e_valid  = 1'b0;
    bit e_led    = 1'b0;

    // Advance the model over the clock edge that just occurred.
    task automatic model_step();
        int n;
        int cnt;
        n = cyc - 1;
        if (p_rst) begin
            m_active = 1'b0;
            e_valid  = 1'b0;
            e_freq   = 0;
            e_ovf    = 1'b0;
            e_led    = 1'b0;
        end else begin
            e_valid = 1'b0;
            if (m_active) begin
                if (n == m_ws + c_g) begin
                    cnt     = window_rises(m_ws, n - 1);
                    e_freq  = (cnt > c_maxc) ? c_maxc : cnt;
                    e_ovf   = (cnt > c_maxc);
                    e_valid = 1'b1;
                    e_led   = !e_led;
                    if (p_en) m_ws = n;
                    else      m_active = 1'b0;
                end else if (!p_en) begin
                    m_active = 1'b0;
                end
            end else if (p_en) begin
                m_active = 1'b1;
                m_ws     = n;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            model_step();
            check_value("valid", 32'(freq_valid), 32'(e_valid));
            check_value("freq",  32'(freq),       32'(e_freq));
            check_value("ovf",   32'(freq_ovf),   32'(e_ovf));
            check_value("led",   32'(led),        32'(e_led));
        end
    end

    // Square-wave source: toggles every 'half' clocks; half = 0 holds hold_val.
    int half     = 0;
    bit hold_val = 1'b0;

    initial begin
        sig_in = 1'b0;
        forever begin
            if (half == 0) begin
                sig_in = hold_val;
                @(negedge clk);
            end else begin
                repeat (half) @(negedge clk);
                sig_in = ~sig_in;
            end
        end
    end

    task automatic wait_strobe(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (freq_valid === 1'b1) begin
                at = cyc;
                break;
            end
        end
        check_value("strobe_seen", 32'(at >= 0), 32'd1);
    endtask

    int             c0;
    int             s0;
    int             s1;
    int             s2;
    int             seen;
    logic           l0;
    logic [c_w-1:0] f0;

    initial begin
        rst     = 1'b1;
        meas_en = 1'b0;
        repeat (3) @(negedge clk);
        check_value("rst_freq",  32'(freq),       32'd0);
        check_value("rst_ovf",   32'(freq_ovf),   32'd0);
        check_value("rst_valid", 32'(freq_valid), 32'd0);
        check_value("rst_led",   32'(led),        32'd0);
        rst = 1'b0;

        // Basic count: 10-cycle period.
        half = 5;
        repeat (7) @(negedge clk);
        meas_en = 1'b1;
        c0 = cyc;
        wait_strobe(250, s0);
        check_value("first_latency", 32'(s0 - c0), 32'd101);
        check_value("basic_range", 32'((freq >= 9) && (freq <= 11)), 32'd1);
        check_value("basic_ovf", 32'(freq_ovf), 32'd0);
        check_value("basic_led", 32'(led), 32'd1);

        // Back-to-back windows at a 4-cycle period.
        half = 2;
        wait_strobe(150, s0);
        wait_strobe(150, s1);
        l0 = led;
        wait_strobe(150, s2);
        check_value("b2b_period", 32'(s2 - s1), 32'd100);
        check_value("b2b_range", 32'((freq >= 24) && (freq <= 26)), 32'd1);
        check_value("b2b_led", 32'(led), 32'(!l0));

        // Saturation at the fastest rate, then recovery at a slow rate.
        half = 1;
        wait_strobe(150, s0);
        wait_strobe(150, s1);
        check_value("sat_freq", 32'(freq), 32'(c_maxc));
        check_value("sat_ovf", 32'(freq_ovf), 32'd1);
        half = 10;
        wait_strobe(150, s0);
        wait_strobe(150, s1);
        check_value("slow_range", 32'((freq >= 4) && (freq <= 6)), 32'd1);
        check_value("slow_ovf", 32'(freq_ovf), 32'd0);

        // Abort mid-window.
        half = 3;
        wait_strobe(150, s0);
        repeat (50) @(negedge clk);
        f0 = freq;
        l0 = led;
        meas_en = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (freq_valid) seen++;
        end
        check_value("abort_no_strobe", 32'(seen), 32'd0);
        check_value("abort_freq_hold", 32'(freq), 32'(f0));
        check_value("abort_led_hold", 32'(led), 32'(l0));
        meas_en = 1'b1;
        c0 = cyc;
        wait_strobe(250, s1);
        check_value("rearm_latency", 32'(s1 - c0), 32'd101);

        // Reset mid-window, counted from the cycle rst is raised.
        wait_strobe(150, s0);
        repeat (70) @(negedge clk);
        rst = 1'b1;
        c0 = cyc;
        @(negedge clk);
        rst = 1'b0;
        check_value("mrst_freq",  32'(freq),       32'd0);
        check_value("mrst_ovf",   32'(freq_ovf),   32'd0);
        check_value("mrst_valid", 32'(freq_valid), 32'd0);
        check_value("mrst_led",   32'(led),        32'd0);
        wait_strobe(250, s1);
        check_value("mrst_latency", 32'(s1 - c0), 32'd102);

        // Input held high.
        half     = 0;
        hold_val = 1'b1;
        wait_strobe(150, s0);
        wait_strobe(150, s1);
        wait_strobe(150, s2);
        check_value("zero_freq", 32'(freq), 32'd0);
        check_value("zero_ovf", 32'(freq_ovf), 32'd0);
        check_value("zero_period", 32'(s2 - s1), 32'd100);

        // Randomised rates, aborts and resets; the model checks every cycle.
        for (int k = 0; k < 25; k++) begin
            half     = $urandom_range(0, 8);
            hold_val = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 19))
                0: begin
                    rst = 1'b1;
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                    rst = 1'b0;
                end
                1, 2, 3: begin
                    meas_en = 1'b0;
                    repeat ($urandom_range(1, 120)) @(negedge clk);
                    meas_en = 1'b1;
                end
                default: ;
            endcase
            repeat ($urandom_range(20, 250)) @(negedge clk);
        end

        meas_en = 1'b0;
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
